// File: rtl/fir_mac_serial.sv
// fir_mac_serial: time-multiplexed single-MAC FIR engine.
// Keeps the last Order+1 samples in a circular delay line and walks the taps
// one per cycle against a registered-read coefficient ROM, producing one
// rounded, saturated output per accepted sample.
module fir_mac_serial #(
  parameter int Order_MSB  = 5,
  parameter int Filter_MSB = 15,
  parameter int Order      = 39,
  parameter int ACC_W      = 38,
  parameter int OUT_SHIFT  = 15
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic signed [Filter_MSB:0] sample_in,
  input  logic                       sample_valid,
  output logic                       sample_ready,
  output logic        [Order_MSB:0]  coef_addr,
  input  logic signed [Filter_MSB:0] coef_bits,
  output logic signed [Filter_MSB:0] y_out,
  output logic                       y_valid,
  output logic                       busy
);

  localparam int TAPS = Order + 1;
  localparam int PW   = 2 * (Filter_MSB + 1);
  localparam logic [Order_MSB:0] K_LAST = (Order_MSB + 1)'(Order);
  localparam logic [Order_MSB:0] TAPS_W = (Order_MSB + 1)'(TAPS);
  localparam logic signed [ACC_W-1:0] RND =
    {{(ACC_W - OUT_SHIFT){1'b0}}, 1'b1, {(OUT_SHIFT - 1){1'b0}}};
  localparam logic signed [ACC_W-1:0] Y_MAX =
    {{(ACC_W - Filter_MSB){1'b0}}, {Filter_MSB{1'b1}}};
  localparam logic signed [ACC_W-1:0] Y_MIN =
    {{(ACC_W - Filter_MSB){1'b1}}, {Filter_MSB{1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t                     r_state, w_state_next;
  logic signed [Filter_MSB:0] r_line [0:Order];
  logic        [Order_MSB:0]  r_wr_ptr, r_base, r_k;
  logic signed [Filter_MSB:0] r_x_q;
  logic                       r_mac_en;
  logic signed [ACC_W-1:0]    r_acc;
  logic signed [Filter_MSB:0] r_y_out;
  logic                       r_y_valid;

  logic                       w_accept;
  logic        [Order_MSB:0]  w_rd_idx;
  logic signed [PW-1:0]       w_prod;
  logic signed [ACC_W-1:0]    w_prod_ext, w_acc_sum, w_rounded, w_shifted;
  logic signed [Filter_MSB:0] w_y_sat;

  // Tap k reads the sample k steps older than the newest one, wrapping the ring.
  assign w_rd_idx   = (r_base >= r_k) ? (r_base - r_k) : (r_base + (TAPS_W - r_k));
  assign w_accept   = sample_valid && sample_ready;
  assign w_prod     = coef_bits * r_x_q;
  assign w_prod_ext = {{(ACC_W - PW){w_prod[PW-1]}}, w_prod};
  assign w_acc_sum  = r_acc + w_prod_ext;
  assign w_rounded  = w_acc_sum + RND;
  assign w_shifted  = w_rounded >>> OUT_SHIFT;

  assign coef_addr = r_k;
  assign y_out     = r_y_out;
  assign y_valid   = r_y_valid;

  // Clamp the rounded result into the signed output range.
  always_comb begin
    w_y_sat = w_shifted[Filter_MSB:0];
    if (w_shifted > Y_MAX) begin
      w_y_sat = Y_MAX[Filter_MSB:0];
    end else if (w_shifted < Y_MIN) begin
      w_y_sat = Y_MIN[Filter_MSB:0];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: one accept, Order+1 tap cycles, one drain cycle.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_next = S_RUN;
      S_RUN:   if (r_k == K_LAST) w_state_next = S_DRAIN;
      S_DRAIN: w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    sample_ready = (r_state == S_IDLE);
    busy         = (r_state == S_RUN) || (r_state == S_DRAIN);
  end

  // Delay line: the newest sample overwrites the oldest slot on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TAPS; i++) begin
        r_line[i] <= '0;
      end
    end else if (w_accept) begin
      r_line[r_wr_ptr] <= sample_in;
    end
  end

  // Datapath: pointer bookkeeping, tap fetch, MAC, and output rounding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr  <= '0;
      r_base    <= '0;
      r_k       <= '0;
      r_x_q     <= '0;
      r_mac_en  <= 1'b0;
      r_acc     <= '0;
      r_y_out   <= '0;
      r_y_valid <= 1'b0;
    end else begin
      r_y_valid <= 1'b0;
      r_mac_en  <= 1'b0;
      // x_q was fetched one cycle before, matching the ROM read latency.
      if (r_mac_en) begin
        r_acc <= w_acc_sum;
      end
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_base   <= r_wr_ptr;
            r_wr_ptr <= (r_wr_ptr == K_LAST) ? '0 : r_wr_ptr + 1'b1;
            r_k      <= '0;
            r_acc    <= '0;
          end
        end
        S_RUN: begin
          r_x_q    <= r_line[w_rd_idx];
          r_mac_en <= 1'b1;
          // k stops on the last tap so coef_addr holds it while idle.
          if (r_k != K_LAST) begin
            r_k <= r_k + 1'b1;
          end
        end
        S_DRAIN: begin
          r_y_out   <= w_y_sat;
          r_y_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_serial.sv
// Testbench for fir_mac_serial: coefficient ROM model, table-driven impulse
// vectors, hand sequences for reset/DC/saturation/handshake, and random
// samples checked against a direct convolution model.
module tb_fir_mac_serial;

  localparam int TAPS = 40;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic signed [15:0] sample_in = '0;
  logic               sample_valid = 1'b0;
  logic               sample_ready;
  logic        [5:0]  coef_addr;
  logic signed [15:0] coef_bits = '0;
  logic signed [15:0] y_out;
  logic               y_valid;
  logic               busy;

  int rom [0:TAPS-1];
  int hist[$];
  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int x;
    int y;
  } vec_t;
  vec_t vecs [0:TAPS];

  fir_mac_serial dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .coef_addr    (coef_addr),
    .coef_bits    (coef_bits),
    .y_out        (y_out),
    .y_valid      (y_valid),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Registered-read coefficient ROM.
  always @(posedge clk) coef_bits <= 16'(rom[coef_addr]);

  // Direct convolution over the whole sample history, Q15 round and clamp.
  function automatic int model_y();
    longint acc = 0;
    for (int k = 0; k < TAPS; k++) begin
      int idx = hist.size() - 1 - k;
      if (idx >= 0) acc += longint'(rom[k]) * longint'(hist[idx]);
    end
    acc = (acc + 64'sd16384) >>> 15;
    if (acc > 32767) acc = 32767;
    if (acc < -32768) acc = -32768;
    return int'(acc);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One full transaction: handshake, then wait for the result and check it.
  task automatic run_sample(input int x, input string name, output int y);
    int guard = 0;
    int n = 0;
    int exp;
    @(negedge clk);
    while (!sample_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!sample_ready) begin
      check({name, "_ready_timeout"}, 0, 1);
      y = 0;
      return;
    end
    sample_in    = 16'(x);
    sample_valid = 1'b1;
    @(posedge clk);
    hist.push_back(x);
    exp = model_y();
    @(negedge clk);
    sample_valid = 1'b0;
    while (1) begin
      @(posedge clk);
      #1;
      n++;
      if (y_valid || n >= 100) break;
    end
    check({name, "_latency"}, y_valid ? n + 1 : -1, 42);
    check({name, "_y"}, int'(y_out), exp);
    y = int'(y_out);
    $display("txn %s x=%0d y=%0d exp=%0d cycles=%0d", name, x, y, exp, n + 1);
  endtask

  function automatic int sgn(input int v);
    return (v > 0) ? 1 : ((v < 0) ? -1 : 0);
  endfunction

  initial begin
    int h [0:19] = '{-360, -383, -350, -280, -170, -40, 90, 200, 3280, -2690,
                     4290, -3780, 110, -20, -150, -250, -600, -580, -475, 2369};
    int y;
    int seen;
    int last_acc;
    int n_acc;
    int exp_y[$];
    int exp_cyc[$];

    for (int k = 0; k < TAPS; k++) rom[k] = (k < 20) ? h[k] : h[TAPS - 1 - k];
    for (int i = 0; i <= TAPS; i++) begin
      vecs[i].x = (i == 0) ? 32767 : 0;
      vecs[i].y = (i < TAPS) ? rom[i] : 0;
    end

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_y_out", int'(y_out), 0);
    check("rst_y_valid", int'(y_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_coef_addr", int'(coef_addr), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_ready", int'(sample_ready), 1);

    // One sample so y_out is non-zero, then reset in the middle of a run.
    run_sample(20000, "pre_rst", y);
    @(negedge clk);
    sample_in    = 16'sd12345;
    sample_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sample_valid = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    check("midrun_busy_before", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("midrun_rst_y_out", int'(y_out), 0);
    check("midrun_rst_busy", int'(busy), 0);
    check("midrun_rst_coef_addr", int'(coef_addr), 0);
    check("midrun_rst_y_valid", int'(y_valid), 0);
    hist.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midrun_rel_ready", int'(sample_ready), 1);
    seen = 0;
    repeat (60) begin
      @(posedge clk);
      #1;
      if (y_valid) seen++;
    end
    check("midrun_no_y_valid", seen, 0);

    // Impulse table: outputs reproduce the coefficients (history was cleared).
    for (int i = 0; i <= TAPS; i++) begin
      run_sample(vecs[i].x, $sformatf("imp%0d", i), y);
      check($sformatf("imp%0d_table", i), y, vecs[i].y);
    end

    // DC: full-scale input settles to the coefficient sum.
    for (int i = 0; i < 80; i++) begin
      run_sample(32767, $sformatf("dc%0d", i), y);
      if (i >= 39) check($sformatf("dc%0d_settled", i), y, 422);
    end

    // Saturation, positive then negative.
    for (int j = 0; j < TAPS; j++) run_sample(sgn(rom[TAPS - 1 - j]) * 32767, "satp", y);
    check("sat_pos", y, 32767);
    for (int j = 0; j < TAPS; j++) run_sample(-sgn(rom[TAPS - 1 - j]) * 32767, "satn", y);
    check("sat_neg", y, -32768);

    // Random samples across several ring wraps.
    for (int i = 0; i < 100; i++) begin
      run_sample(int'($urandom_range(65535)) - 32768, $sformatf("rnd%0d", i), y);
    end

    // Valid held high with data changing every cycle: only accepted words count.
    last_acc = -1;
    n_acc    = 0;
    for (int t = 0; t < 360; t++) begin
      @(negedge clk);
      sample_valid = (t < 300);
      sample_in    = 16'($urandom_range(65535));
      if (sample_valid && sample_ready) begin
        hist.push_back(int'(sample_in));
        exp_y.push_back(model_y());
        exp_cyc.push_back(t + 42);
        if (last_acc >= 0) check("hs_spacing", t - last_acc, 42);
        last_acc = t;
        n_acc++;
      end
      @(posedge clk);
      #1;
      if (y_valid) begin
        if (exp_y.size() == 0) begin
          check("hs_spurious_y_valid", 1, 0);
        end else begin
          check("hs_cycle", t + 1, exp_cyc.pop_front());
          check("hs_y", int'(y_out), exp_y.pop_front());
          $display("txn hs t=%0d y=%0d", t + 1, int'(y_out));
        end
      end else if (exp_cyc.size() != 0 && exp_cyc[0] <= t + 1) begin
        check("hs_missing_y_valid", 0, 1);
        void'(exp_cyc.pop_front());
        void'(exp_y.pop_front());
      end
    end
    sample_valid = 1'b0;
    check("hs_accepts", n_acc, 8);
    check("hs_outstanding", exp_y.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
